// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op classification for the iterative ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIVU = 4'b1010,
    OP_REMU = 4'b1011,
    OP_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide, one bit per cycle.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             active_q, active_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sum;

  // MUL: a_q multiplicand, b_q multiplier, acc_q product.
  // DIV: a_q divisor, b_q dividend shifting out / quotient shifting in, acc_q remainder.
  always_comb begin
    active_d = active_q;
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    dz_d     = dz_q;
    done     = 1'b0;
    result   = '0;

    rem_shift = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, a_q};
    sum       = acc_q[WIDTH-1:0] + a_q;

    if (start) begin
      active_d = 1'b1;
      count_d  = '0;
      op_d     = op;
      acc_d    = '0;
      dz_d     = (b == '0);
      if (op == OP_MUL) begin
        a_d = a;
        b_d = b;
      end else begin
        // On divide-by-zero the divisor is useless, so keep the dividend for REMU.
        a_d = (b == '0) ? a : b;
        b_d = a;
      end
    end else if (active_q) begin
      count_d = count_q + 1'b1;
      if (op_q == OP_MUL) begin
        if (b_q[0]) acc_d = {1'b0, sum};
        a_d = a_q << 1;
        b_d = b_q >> 1;
      end else if (!diff[WIDTH]) begin
        acc_d = diff;
        b_d   = {b_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_shift;
        b_d   = {b_q[WIDTH-2:0], 1'b0};
      end
      if (count_q == LAST) begin
        done     = 1'b1;
        active_d = 1'b0;
      end
    end

    // Taken from the next-state values so the final iteration and result capture share an edge.
    case (op_q)
      OP_MUL:  result = acc_d[WIDTH-1:0];
      OP_DIVU: result = dz_q ? '1 : b_d;
      OP_REMU: result = dz_q ? a_q : acc_d[WIDTH-1:0];
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      count_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Handshaked execute unit: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  ALUoperation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUresult,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_out;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign shamt = operand2[SHW-1:0];

  always_comb begin
    alu_out = '0;
    case (ALUoperation)
      OP_AND:  alu_out = operand1 & operand2;
      OP_OR:   alu_out = operand1 | operand2;
      OP_ADD:  alu_out = operand1 + operand2;
      OP_SUB:  alu_out = operand1 - operand2;
      OP_XOR:  alu_out = operand1 ^ operand2;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      OP_SLL:  alu_out = operand1 << shamt;
      OP_SRL:  alu_out = operand1 >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(operand1) >>> shamt);
      default: alu_out = '0;
    endcase
  end

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (4'(ALUoperation)),
    .a      (operand1),
    .b      (operand2),
    .done   (md_done),
    .result (md_result)
  );

  // DONE never accepts, even with out_ready high: one bubble keeps the handshake path short.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_iterative(4'(ALUoperation))) begin
            md_start = 1'b1;
            state_d  = BUSY;
          end else begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          result_d = md_result;
          zero_d   = (md_result == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign ALUresult = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed scoreboard bench for iter_alu at WIDTH=32 plus a WIDTH=8 instance.
module tb_iter_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, in_ready, out_valid, zero, busy;
  logic [3:0]  op;
  logic [31:0] a, b, res;

  logic        in_valid8, out_ready8, in_ready8, out_valid8, zero8, busy8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;

  iter_alu #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUoperation(op), .operand1(a), .operand2(b), .out_valid(out_valid),
    .out_ready(out_ready), .ALUresult(res), .zero(zero), .busy(busy)
  );

  iter_alu #(.WIDTH(8), .OP_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .ALUoperation(op8), .operand1(a8), .operand2(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .ALUresult(res8), .zero(zero8), .busy(busy8)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic g_valid(input bit w8);
    return w8 ? out_valid8 : out_valid;
  endfunction
  function automatic logic g_ready(input bit w8);
    return w8 ? in_ready8 : in_ready;
  endfunction
  function automatic logic g_zero(input bit w8);
    return w8 ? zero8 : zero;
  endfunction
  function automatic logic [31:0] g_res(input bit w8);
    return w8 ? {24'h0, res8} : res;
  endfunction

  task automatic run_op(input bit w8, input string tag, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input int lat, input bit hold);
    exp_t e;
    int   cyc;
    e.res = expv; e.zero = (expv == 32'h0); e.lat = lat; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(g_ready(w8)), 32'h1);
    if (w8) begin
      in_valid8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; out_ready8 = 1'b1;
    end else begin
      in_valid = 1'b1; op = o; a = x; b = y; out_ready = !hold;
    end
    @(negedge clk);
    in_valid = 1'b0; in_valid8 = 1'b0;
    cyc = 1;
    while (!g_valid(w8) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
    chk({e.tag, "_result"}, g_res(w8), e.res);
    chk({e.tag, "_zero"}, 32'(g_zero(w8)), 32'(e.zero));
    $display("txn %s: result=0x%08h zero=%0b latency=%0d", e.tag, g_res(w8), g_zero(w8), cyc);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1;
        @(negedge clk);
        chk({e.tag, "_hold_valid"}, 32'(out_valid), 32'h1);
        chk({e.tag, "_hold_result"}, res, e.res);
        chk({e.tag, "_hold_zero"}, 32'(zero), 32'(e.zero));
        chk({e.tag, "_hold_in_ready"}, 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk({e.tag, "_release_valid"}, 32'(out_valid), 32'h0);
      chk({e.tag, "_release_busy"}, 32'(busy), 32'h0);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int rose;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_result", res, 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst8_in_ready", 32'(in_ready8), 32'h1);
    chk("rst8_result", {24'h0, res8}, 32'h0);
    rst_n = 1'b1;

    run_op(0, "add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
    run_op(0, "sub_wrap", OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, 0);
    run_op(0, "slt_neg", OP_SLT, 32'hFFFF_FFFB, 32'h3, 32'h1, 1, 0);
    run_op(0, "slt_pos", OP_SLT, 32'h3, 32'hFFFF_FFFB, 32'h0, 1, 0);
    run_op(0, "sra", OP_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, 1, 0);
    run_op(0, "srl_shamt", OP_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 1, 0);
    run_op(0, "sll31", OP_SLL, 32'h1, 32'h1F, 32'h8000_0000, 1, 0);
    run_op(0, "xor_eq", OP_XOR, 32'h1234_5678, 32'h1234_5678, 32'h0, 1, 0);
    run_op(0, "and", OP_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1, 0);
    run_op(0, "or", OP_OR, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1, 0);
    run_op(0, "undef_op", 4'b1111, 32'hDEAD_BEEF, 32'h1, 32'h0, 1, 0);
    run_op(0, "mul", OP_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33, 0);
    run_op(0, "mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33, 0);
    run_op(0, "divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op(0, "remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op(0, "divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, 0);
    run_op(0, "remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 0);
    run_op(0, "divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 33, 0);
    run_op(0, "remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 33, 0);
    run_op(0, "hold_sub", OP_SUB, 32'd10, 32'd3, 32'd7, 1, 1);
    run_op(0, "hold_mul0", OP_MUL, 32'd0, 32'd9, 32'd0, 33, 1);

    // Abort a multiply with reset twelve cycles in.
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'h1);
    chk("abort_in_ready_before", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_in_ready", 32'(in_ready), 32'h1);
    chk("abort_out_valid", 32'(out_valid), 32'h0);
    chk("abort_result", res, 32'h0);
    chk("abort_zero", 32'(zero), 32'h0);
    rst_n = 1'b1;
    rose = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) rose++;
    end
    chk("abort_no_valid", 32'(rose), 32'h0);
    $display("txn abort_mul: out_valid rises after abort=%0d", rose);
    run_op(0, "after_abort", OP_ADD, 32'd2, 32'd3, 32'd5, 1, 0);

    run_op(1, "w8_add", OP_ADD, 32'hFF, 32'h01, 32'h0, 1, 0);
    run_op(1, "w8_sra", OP_SRA, 32'h80, 32'h0B, 32'hF0, 1, 0);
    run_op(1, "w8_mul", OP_MUL, 32'd13, 32'd11, 32'h8F, 9, 0);
    run_op(1, "w8_divu", OP_DIVU, 32'd200, 32'd7, 32'd28, 9, 0);
    run_op(1, "w8_remu", OP_REMU, 32'd200, 32'd7, 32'd4, 9, 0);
    run_op(1, "w8_divu_by0", OP_DIVU, 32'd9, 32'd0, 32'hFF, 9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
